// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_AE_LEVEL   = 2;

  // Ceiling log2, usable in constant expressions. clog2(1) == 0.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter: counts 0..DEPTH-1 and returns to 0, so DEPTH need
// not be a power of two.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    inc,
  output logic [clog2(DEPTH)-1:0] ptr
);

  localparam int              PW   = clog2(DEPTH);
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: clear wins over increment; explicit wrap after the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  // Pointer register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, full/empty and almost
// flags, sticky overflow/underflow, synchronous flush and a registered read
// port with a one-cycle data_valid strobe.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       en_write,
  input  logic                       en_read,
  input  logic                       flush,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [clog2(DEPTH+1)-1:0]  count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  // Storage is never reset; only pointers and count define what is valid.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         ptr_wr;
  logic [PW-1:0]         ptr_rd;

  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  overflow_q;
  logic                  overflow_d;
  logic                  underflow_q;
  logic                  underflow_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;

  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode the registered count directly, so they carry no extra latency.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Acceptance uses pre-edge full/empty; a flush cycle ignores both requests.
  assign wr_acc = en_write & ~full_w  & ~flush;
  assign rd_acc = en_read  & ~empty_w & ~flush;

  fifo_ptr #(.DEPTH(DEPTH)) u_ptr_wr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wr_acc),
    .ptr   (ptr_wr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_ptr_rd (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd_acc),
    .ptr   (ptr_rd)
  );

  // Next occupancy and sticky error state; flush clears everything.
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q  | (en_write & full_w);
    underflow_d = underflow_q | (en_read  & empty_w);
    if (flush) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Accepted writes land in the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[ptr_wr] <= data_in;
    end
  end

  // Count and error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Registered read port: data_out only changes on an accepted read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_acc;
      if (rd_acc) begin
        data_out_q <= mem_q[ptr_rd];
      end
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (8 x 16). Stimulus pushes expected read
// data into a scoreboard queue; a negedge monitor pops and compares whenever
// data_valid is presented.
module tb_fifo_sync_param;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          en_write;
  logic          en_read;
  logic          flush;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  fifo_sync_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .en_write     (en_write),
    .en_read      (en_read),
    .flush        (flush),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference state
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_out = '0;
  bit            m_ov = 0;
  bit            m_un = 0;
  bit            m_dv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
  endtask

  task automatic check_state();
    int sz;
    sz = mdl.size();
    chk("count",        32'(count),        32'(sz));
    chk("full",         32'(full),         32'(sz == DEPTH));
    chk("empty",        32'(empty),        32'(sz == 0));
    chk("almost_full",  32'(almost_full),  32'(sz >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
    chk("data_valid",   32'(data_valid),   32'(m_dv));
    chk("data_out",     32'(data_out),     32'(last_out));
  endtask

  task automatic model_reset();
    mdl.delete();
    exp_q.delete();
    last_out = '0;
    m_ov = 0;
    m_un = 0;
    m_dv = 0;
  endtask

  // One clock of stimulus; the reference decides acceptance from pre-edge state.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit f);
    bit wacc;
    bit racc;
    en_write = w;
    en_read  = r;
    data_in  = d;
    flush    = f;
    wacc = w && !f && (mdl.size() < DEPTH);
    racc = r && !f && (mdl.size() > 0);
    if (f) begin
      mdl.delete();
      m_ov = 0;
      m_un = 0;
    end else begin
      if (w && !wacc) m_ov = 1;
      if (r && !racc) m_un = 1;
    end
    if (racc) begin
      last_out = mdl.pop_front();
      exp_q.push_back(last_out);
    end
    if (wacc) mdl.push_back(d);
    m_dv = racc;
    @(posedge clk);
    #1;
    en_write = 1'b0;
    en_read  = 1'b0;
    flush    = 1'b0;
    check_state();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_state();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got data_valid=1 data_out=%0h, required no read", data_out);
      end else begin
        chk("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset    = 1'b0;
    data_in  = '0;
    en_write = 1'b0;
    en_read  = 1'b0;
    flush    = 1'b0;
    #2;
    check_state();            // async reset effective before any edge
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: fill 0x01..0x10 then drain in order
    apply_reset();
    for (int i = 1; i <= 16; i++) step(1, 0, 8'(i), 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);

    // 2: overflow while full; 0xAA must never be read
    apply_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h80 + i), 0);
    step(1, 0, 8'hAA, 0);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);

    // 3: underflow from empty; data_out holds 0x00
    apply_reset();
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // 4: wrap-around across slot 15 -> 0
    apply_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h20 + i), 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 8'(8'h30 + i), 0);
    for (int i = 0; i < 12; i++) step(0, 1, 8'h00, 0);

    // 5: simultaneous read/write at count 5, then both at empty
    apply_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i), 0);
    for (int i = 0; i < 20; i++) step(1, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 0);
    step(1, 1, 8'hC3, 0);
    step(0, 1, 8'h00, 0);
    // full with both high: read wins, write rejected
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'hD0 + i), 0);
    step(1, 1, 8'hEE, 0);

    // 6a: almost flags over the full range
    apply_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h70 + i), 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);

    // 6b: async reset between edges during a read burst
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h90 + i), 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_state();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_state();

    // 6c: flush at count 7 with both errors set; requests ignored that cycle
    step(0, 1, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'hA0 + i), 0);
    step(1, 0, 8'hFF, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 8'h00, 0);
    step(1, 1, 8'h5A, 1);
    step(0, 0, 8'h00, 0);
    step(1, 0, 8'h3C, 0);
    step(0, 1, 8'h00, 0);

    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
